shift_reg_seq: RTL and testbench

//   Parametrised N-bit serial shift register with a built-in bit sequencer, the next-generation

---
 rtl/shift_reg_seq.sv | 72 +++++++
 tb/tb_shift_reg_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: N-bit parallel-load serial shift register with built-in N-shift sequencer
module shift_reg_seq #(
    parameter int             N       = 8,
    parameter logic [N-1:0]   RST_VAL = '0,
    localparam int            CNT_W   = $clog2(N + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             ld,
    input  logic [N-1:0]     d_in,
    input  logic             start,
    input  logic             dir,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [N-1:0]     q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [N-1:0]     q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    // next-state: load/start only in IDLE, one shift per edge in SHIFT, one-cycle DONE
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    q_d = d_in;
                end else if (start) begin
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                q_d     = dir_q ? {q_q[N-2:0], ser_in} : {ser_in, q_q[N-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(N - 1)) ? DONE : SHIFT;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset aborts any operation immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            q_q     <= RST_VAL;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
    assign q       = q_q;
    assign ser_out = dir_q ? q_q[N-1] : q_q[0];
    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: self-checking bench for shift_reg_seq with an operation-level model
module tb_shift_reg_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       ld8 = 0, start8 = 0, dir8 = 0, si8 = 0, tie8 = 0;
    logic [7:0] d8 = '0;
    logic       ser_in8, so8, busy8, done8;
    logic [7:0] q8;
    logic [3:0] cnt8;
    assign ser_in8 = tie8 ? so8 : si8;

    logic        ld16 = 0, start16 = 0, dir16 = 0, si16 = 0;
    logic [15:0] d16 = '0;
    logic        so16, busy16, done16;
    logic [15:0] q16;
    logic [4:0]  cnt16;

    shift_reg_seq #(.N(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .ld(ld8), .d_in(d8), .start(start8), .dir(dir8),
        .ser_in(ser_in8), .ser_out(so8), .q(q8), .busy(busy8), .done(done8), .bit_cnt(cnt8)
    );
    shift_reg_seq #(.N(16), .RST_VAL(16'h1234)) dut16 (
        .i_clk(clk), .i_rst(rst), .ld(ld16), .d_in(d16), .start(start16), .dir(dir16),
        .ser_in(si16), .ser_out(so16), .q(q16), .busy(busy16), .done(done16), .bit_cnt(cnt16)
    );

    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is described by the value at start, the direction and the
    // list of bits taken in; q is derived arithmetically from those.
    logic       m_act = 0, m_done = 0, m_dir = 0;
    logic [7:0] m_pre = '0, m_qidle = '0;
    int         m_k = 0;
    logic       m_in[$];

    function automatic logic [7:0] exp_q();
        logic [15:0] v;
        if (!m_act && !m_done) return m_qidle;
        v = m_dir ? ({8'h00, m_pre} << m_k) : ({8'h00, m_pre} >> m_k);
        for (int i = 0; i < m_k; i++)
            if (m_in[i]) v[m_dir ? (m_k - 1 - i) : (8 - m_k + i)] = 1'b1;
        return v[7:0];
    endfunction

    always @(posedge rst) begin
        m_act = 0; m_done = 0; m_dir = 0; m_k = 0; m_qidle = '0; m_in.delete();
    end

    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            if (m_done) begin
                m_qidle = exp_q();
                m_done  = 0;
            end else if (m_act) begin
                m_in.push_back(ser_in8);
                m_k++;
                if (m_k == 8) begin m_act = 0; m_done = 1; end
            end else if (ld8) begin
                m_qidle = d8;
            end else if (start8) begin
                m_act = 1; m_k = 0; m_pre = m_qidle; m_dir = dir8; m_in.delete();
            end
        end
    end

    logic chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] eq;
            eq = exp_q();
            chk("model_q", q8, eq);
            chk("model_busy", busy8, m_act);
            chk("model_done", done8, m_done);
            chk("model_cnt", cnt8, m_act ? m_k : (m_done ? 8 : 0));
            chk("model_ser_out", so8, m_dir ? eq[7] : eq[0]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Load, start, then run until done; edges counts the start edge as the first.
    task automatic run8(input logic [7:0] val, input logic dv, input logic si, input logic tgl,
                        output int edges, output int busyc, output logic [7:0] seq);
        ld8 = 1; d8 = val; tick();
        ld8 = 0; start8 = 1; dir8 = dv; si8 = si; tick();
        start8 = 0;
        edges = 1; busyc = 0; seq = '0;
        while (!done8 && edges < 30) begin
            if (busy8) begin
                if (busyc < 8) seq[7 - busyc] = so8;
                chk("cnt_seq", cnt8, edges - 1);
                busyc++;
            end
            if (tgl) begin
                ld8 = 1; d8 = 8'hFF; dir8 = ~dir8; start8 = edges[0];
            end
            tick();
            edges++;
        end
        ld8 = 0; start8 = 0; dir8 = 0;
    endtask

    int e, b, n;
    logic [7:0] sq;
    initial begin
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_q", q8, 8'h00);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_cnt", cnt8, 0);
        chk("rst_q16", q16, 16'h1234);
        chk_en = 1;

        run8(8'hA5, 0, 0, 0, e, b, sq);
        chk("t1_done_edges", e, 9);
        chk("t1_busy_cycles", b, 8);
        chk("t1_ser_seq", sq, 8'hA5);
        chk("t1_q", q8, 8'h00);
        tick();
        chk("t1_done_pulse", done8, 0);

        tie8 = 1;
        run8(8'h81, 1, 0, 0, e, b, sq);
        chk("t2_q", q8, 8'h81);
        chk("t2_ser_seq", sq, 8'h81);
        chk("t2_done_edges", e, 9);
        tick();
        tie8 = 0;

        ld8 = 1; start8 = 1; d8 = 8'h3C; tick();
        ld8 = 0; start8 = 0;
        chk("t3_q", q8, 8'h3C);
        chk("t3_busy", busy8, 0);
        repeat (3) tick();
        chk("t3_no_done", done8, 0);
        chk("t3_busy_late", busy8, 0);

        run8(8'h35, 0, 0, 1, e, b, sq);
        chk("t4_ser_seq", sq, 8'hAC);
        chk("t4_q", q8, 8'h00);
        chk("t4_cnt", cnt8, 8);
        tick();

        ld8 = 1; d8 = 8'hC3; tick();
        ld8 = 0; start8 = 1; tick();
        start8 = 0;
        repeat (3) tick();
        chk("t5_cnt_before", cnt8, 3);
        #2 rst = 1;
        #1;
        chk("t5_q", q8, 8'h00);
        chk("t5_busy", busy8, 0);
        chk("t5_cnt", cnt8, 0);
        chk("t5_done", done8, 0);
        tick();
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t5_no_done", done8, 0);
        end

        ld16 = 1; d16 = 16'h8001; tick();
        ld16 = 0; start16 = 1; dir16 = 0; si16 = 1; tick();
        start16 = 0;
        n = 1; b = 0;
        while (!done16 && n < 40) begin
            if (busy16) b++;
            tick();
            n++;
        end
        chk("t6_done_edges", n, 17);
        chk("t6_busy_cycles", b, 16);
        chk("t6_q", q16, 16'hFFFF);
        chk("t6_cnt", cnt16, 16);
        tick();
        chk("t6_cnt_idle", cnt16, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
